// File: rtl/if_fetch_ctrl.sv
// Fetch-stage controller: owns the PC, drives instruction memory, fills the IF/ID register.
// Optional misaligned-redirect trap enabled by defining IF_MISALIGN_CHK_EN.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BOOT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_instr,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_target,
`ifdef IF_MISALIGN_CHK_EN
    output logic        o_misalign,
`endif
    output logic        o_id_valid,
    output logic [31:0] o_id_instr,
    output logic [31:0] o_id_pc,
    output logic [31:0] o_id_pc_plus4,
    input  logic        i_id_ready,
    output logic [31:0] o_fetch_cnt
);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

    localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES - 1);

    state_t      state;
    logic [3:0]  boot_cnt;
    logic [31:0] pc;
    logic        load;

    assign o_imem_addr   = pc;
    assign o_id_pc_plus4 = o_id_pc + 32'd4;
    // IF/ID accepts a new word when it is empty or decode drains it this cycle
    assign load          = !o_id_valid || i_id_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_BOOT;
            boot_cnt    <= BOOT_INIT;
            pc          <= RESET_PC;
            o_id_valid  <= 1'b0;
            o_id_instr  <= 32'h0000_0000;
            o_id_pc     <= 32'h0000_0000;
            o_fetch_cnt <= 32'h0000_0000;
`ifdef IF_MISALIGN_CHK_EN
            o_misalign  <= 1'b0;
`endif
        end else if (state != S_HALT) begin
            if (state == S_BOOT) begin
                if (boot_cnt == 4'd0)
                    state <= S_RUN;
                else
                    boot_cnt <= boot_cnt - 4'd1;
            end
            // Redirect wins over capture and flushes whatever IF/ID holds
            if (i_redirect_valid) begin
                o_id_valid <= 1'b0;
`ifdef IF_MISALIGN_CHK_EN
                if (i_redirect_target[1:0] != 2'b00) begin
                    o_misalign <= 1'b1;
                    state      <= S_HALT;
                end else begin
                    pc <= i_redirect_target;
                end
`else
                pc <= i_redirect_target;
`endif
            end else if (state == S_RUN && load) begin
                o_id_valid  <= 1'b1;
                o_id_instr  <= i_imem_instr;
                o_id_pc     <= pc;
                pc          <= pc + 32'd4;
                o_fetch_cnt <= o_fetch_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed-vector bench for if_fetch_ctrl; memory model returns an address-derived word.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst, rv, rdy;
    logic [31:0] tgt;
    logic [31:0] imem_addr, imem_instr, id_instr, id_pc, id_pc_plus4, fetch_cnt;
    logic        id_valid;
`ifdef IF_MISALIGN_CHK_EN
    logic        misalign;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign imem_instr = mem_word(imem_addr);

    if_fetch_ctrl #(.RESET_PC(32'h0), .BOOT_CYCLES(2)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .o_imem_addr(imem_addr),
        .i_imem_instr(imem_instr),
        .i_redirect_valid(rv),
        .i_redirect_target(tgt),
`ifdef IF_MISALIGN_CHK_EN
        .o_misalign(misalign),
`endif
        .o_id_valid(id_valid),
        .o_id_instr(id_instr),
        .o_id_pc(id_pc),
        .o_id_pc_plus4(id_pc_plus4),
        .i_id_ready(rdy),
        .o_fetch_cnt(fetch_cnt)
    );

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] tgt;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
        logic [31:0] ecnt;
        logic        emis;
    } vec_t;

    vec_t tv[$];

    function automatic void add(input logic r, input logic v, input logic [31:0] t, input logic y,
                                input logic ev, input logic [31:0] epc, input logic [31:0] ea,
                                input logic [31:0] ec, input logic em);
        vec_t x;
        x.rst = r; x.rv = v; x.tgt = t; x.rdy = y;
        x.ev = ev; x.epc = epc; x.eaddr = ea; x.ecnt = ec; x.emis = em;
        tv.push_back(x);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; rv = 1'b0; tgt = 32'h0; rdy = 1'b1;

        //   rst rv tgt           rdy  ev epc           addr          cnt mis
        add(1, 0, 0,            1,   0, 0,            0,            0,  0);
        add(1, 0, 0,            1,   0, 0,            0,            0,  0);
        add(0, 0, 0,            1,   0, 0,            0,            0,  0);
        add(0, 0, 0,            1,   0, 0,            0,            0,  0);
        add(0, 0, 0,            1,   1, 0,            4,            1,  0);
        add(0, 0, 0,            1,   1, 4,            8,            2,  0);
        add(0, 0, 0,            1,   1, 8,            12,           3,  0);
        add(0, 0, 0,            0,   1, 8,            12,           3,  0);
        add(0, 0, 0,            0,   1, 8,            12,           3,  0);
        add(0, 0, 0,            0,   1, 8,            12,           3,  0);
        add(0, 0, 0,            1,   1, 12,           16,           4,  0);
        add(0, 0, 0,            1,   1, 16,           20,           5,  0);
        add(0, 0, 0,            1,   1, 20,           24,           6,  0);
        add(0, 0, 0,            1,   1, 24,           28,           7,  0);
        add(0, 0, 0,            1,   1, 28,           32,           8,  0);
        add(0, 0, 0,            1,   1, 32,           36,           9,  0);
        add(0, 1, 16,           1,   0, 32,           16,           9,  0);
        add(0, 0, 0,            1,   1, 16,           20,           10, 0);
        add(0, 0, 0,            0,   1, 16,           20,           10, 0);
        add(0, 1, 100,          0,   0, 16,           100,          10, 0);
        add(0, 0, 0,            0,   1, 100,          104,          11, 0);
        add(0, 1, 32'hFFFF_FFFC, 1,  0, 100,          32'hFFFF_FFFC, 11, 0);
        add(0, 0, 0,            1,   1, 32'hFFFF_FFFC, 0,           12, 0);
        add(0, 0, 0,            1,   1, 0,            4,            13, 0);
        add(0, 0, 0,            0,   1, 0,            4,            13, 0);
        add(1, 1, 200,          0,   0, 0,            0,            0,  0);
        add(1, 0, 0,            1,   0, 0,            0,            0,  0);
        add(0, 1, 32'h40,       1,   0, 0,            32'h40,       0,  0);
        add(0, 0, 0,            1,   0, 0,            32'h40,       0,  0);
        add(0, 0, 0,            1,   1, 32'h40,       32'h44,       1,  0);
`ifdef IF_MISALIGN_CHK_EN
        add(0, 1, 32'h12,       1,   0, 32'h40,       32'h44,       1,  1);
        add(0, 1, 32'h80,       1,   0, 32'h40,       32'h44,       1,  1);
        add(0, 0, 0,            1,   0, 32'h40,       32'h44,       1,  1);
`else
        add(0, 1, 32'h12,       1,   0, 32'h40,       32'h12,       1,  0);
        add(0, 0, 0,            1,   1, 32'h12,       32'h16,       2,  0);
`endif

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            rst = tv[i].rst; rv = tv[i].rv; tgt = tv[i].tgt; rdy = tv[i].rdy;
            @(posedge clk);
            #1;
            chk("id_valid", i, {31'b0, id_valid}, {31'b0, tv[i].ev});
            chk("id_pc", i, id_pc, tv[i].epc);
            chk("imem_addr", i, imem_addr, tv[i].eaddr);
            chk("fetch_cnt", i, fetch_cnt, tv[i].ecnt);
            if (tv[i].ev) begin
                chk("id_instr", i, id_instr, mem_word(tv[i].epc));
                chk("id_pc_plus4", i, id_pc_plus4, tv[i].epc + 32'd4);
            end
            if (tv[i].rst)
                chk("id_instr_rst", i, id_instr, 32'h0);
`ifdef IF_MISALIGN_CHK_EN
            chk("misalign", i, {31'b0, misalign}, {31'b0, tv[i].emis});
`endif
        end

        // Boot latency measured with a bounded wait, then steady one-per-cycle fetch
        @(negedge clk);
        rst = 1'b1; rv = 1'b0; rdy = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        begin
            int cycles = 0;
            while (!id_valid && cycles < 10) begin
                @(posedge clk);
                #1;
                cycles++;
            end
            chk("boot_latency", 0, 32'(cycles), 32'd3);
        end
        chk("boot_first_pc", 0, id_pc, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            chk("stream_valid", k, {31'b0, id_valid}, 32'd1);
            chk("stream_pc", k, id_pc, 32'(4 * k));
            chk("stream_instr", k, id_instr, mem_word(32'(4 * k)));
            chk("stream_cnt", k, fetch_cnt, 32'(k + 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
